// File: rtl/count_down_timer_pkg.sv
// Shared definitions for the count-down timer: mode encodings, FSM states and
// BCD helpers for the {m1, m0, s1, s0, ms1, ms0} display format.
package count_down_timer_pkg;

  localparam int DATA_W = 24;
  localparam int DIGITS = 6;
  localparam int S1_IDX = 3;

  localparam logic [1:0] MODE_CLOCK     = 2'b00;
  localparam logic [1:0] MODE_ALARM_SET = 2'b01;
  localparam logic [1:0] MODE_STOPWATCH = 2'b10;
  localparam logic [1:0] MODE_TIMER     = 2'b11;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_EXPIRED
  } state_e;

  // Tens-of-seconds wraps at 5; every other digit wraps at 9.
  function automatic logic [3:0] digit_limit(int idx);
    return (idx == S1_IDX) ? TENS_MAX : DIGIT_MAX;
  endfunction

  function automatic logic bcd_valid(logic [DATA_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*4 +: 4] > digit_limit(i)) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [DATA_W-1:0] bcd_dec(logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    logic              borrow;
    logic [3:0]        d;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = r[i*4 +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d = digit_limit(i);
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/count_down_timer_if.sv
// Control and display bundle between the mode/keypad logic and the timer.
interface count_down_timer_if;
  import count_down_timer_pkg::*;

  logic [1:0]        model;
  logic              load;
  logic [DATA_W-1:0] preset;
  logic              run;
  logic              clear;
  logic [DATA_W-1:0] timer_num;
  logic              running;
  logic              done;
  logic              alarm;
  logic              load_err;

  modport master (
    output model, load, preset, run, clear,
    input  timer_num, running, done, alarm, load_err
  );

  modport slave (
    input  model, load, preset, run, clear,
    output timer_num, running, done, alarm, load_err
  );

endinterface

// File: rtl/count_down_timer_tick_gen.sv
// 10 ms tick enable: a one-cycle pulse every TICK_DIV enabled cycles.
module tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/count_down_timer.sv
// BCD count-down timer: loads a preset, decrements once per tick while running
// and holds an alarm for ALARM_TICKS ticks after reaching 00:00.00.
module count_down_timer #(
  parameter int TICK_DIV    = 500000,
  parameter int ALARM_TICKS = 300
) (
  input logic               clk,
  input logic               rst,
  count_down_timer_if.slave bus
);
  import count_down_timer_pkg::*;

  localparam int            AW         = $clog2(ALARM_TICKS + 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [AW-1:0]     alarm_cnt_q, alarm_cnt_d;
  logic              done_q, done_d;
  logic              load_err_q, load_err_d;
  logic              alarm_q, running_q;
  logic              tick, restart, mode_ok, load_req, load_rej;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .en      ((state_q == ST_RUN) || (state_q == ST_EXPIRED)),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    mode_ok     = (bus.model == MODE_TIMER);
    load_req    = bus.load && mode_ok && (state_q != ST_RUN);
    load_rej    = load_req && !bcd_valid(bus.preset);
    state_d     = state_q;
    count_d     = count_q;
    alarm_cnt_d = alarm_cnt_q;
    done_d      = 1'b0;
    load_err_d  = 1'b0;

    if (bus.clear) begin
      count_d     = '0;
      state_d     = ST_IDLE;
      alarm_cnt_d = '0;
    end else if (load_req && !load_rej) begin
      count_d     = bus.preset;
      state_d     = ST_IDLE;
      alarm_cnt_d = '0;
    end else begin
      // A rejected load blocks run/pause control this cycle, but the alarm keeps timing.
      load_err_d = load_rej;
      unique case (state_q)
        ST_IDLE: begin
          if (!load_rej && bus.run && mode_ok && (count_q != '0)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!bus.run || !mode_ok) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            count_d = bcd_dec(count_q);
            if (count_q == DATA_W'(1)) begin
              state_d     = ST_EXPIRED;
              done_d      = 1'b1;
              alarm_cnt_d = '0;
            end
          end
        end
        ST_PAUSE: begin
          if (!load_rej && bus.run && mode_ok) state_d = ST_RUN;
        end
        ST_EXPIRED: begin
          if (tick) begin
            if (alarm_cnt_q == ALARM_LAST) begin
              state_d     = ST_IDLE;
              alarm_cnt_d = '0;
            end else begin
              alarm_cnt_d = alarm_cnt_q + AW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    restart = bus.clear ||
              ((state_d != state_q) && ((state_d == ST_RUN) || (state_d == ST_EXPIRED)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      alarm_cnt_q <= '0;
      done_q      <= 1'b0;
      load_err_q  <= 1'b0;
      alarm_q     <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      alarm_cnt_q <= alarm_cnt_d;
      done_q      <= done_d;
      load_err_q  <= load_err_d;
      alarm_q     <= (state_d == ST_EXPIRED);
      running_q   <= (state_d == ST_RUN);
    end
  end

  assign bus.timer_num = count_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.alarm     = alarm_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: doc/count_down_timer.md
# count_down_timer

Count-down timer that complements the count-up stopwatch in the clock design. It is loaded with a preset in the same 24-bit BCD display format {m1, m0, s1, s0, ms1, ms0}, decrements it once per 10 ms tick, and raises a one-cycle `done` pulse and a timed `alarm` level when it reaches 00:00.00. It sits beside the stopwatch, selected by mode 2'b11, and drives the same display mux.

## Interface

Parameters
- `TICK_DIV`, 500000: clk cycles per 10 ms tick (50 MHz). Must be ≥ 2.
- `ALARM_TICKS`, 300: ticks that `alarm` stays high after expiry (3 s).

Ports
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `model`  in  2  mode select; the timer is active only when `model` == 2'b11.
- `load`  in  1  level; copies `preset` into the count.
- `preset`  in  24  BCD preset {m1, m0, s1, s0, ms1, ms0}.
- `run`  in  1  level; 1 = run, 0 = pause.
- `clear`  in  1  synchronous clear.
- `timer_num`  out  24  current BCD count, registered. Reset value 24'h0.
- `running`  out  1  high in state RUN. Reset value 0.
- `done`  out  1  one-cycle pulse on expiry. Reset value 0.
- `alarm`  out  1  high during EXPIRED. Reset value 0.
- `load_err`  out  1  one-cycle pulse when a load is rejected. Reset value 0.

## Operation

- States:
  - IDLE (reset state)
  - RUN
  - PAUSE
  - EXPIRED
- Input priority: `rst` > `clear` > `load` > run/pause control.
- `clear`, accepted in any state and any mode:
  - count ← 0, state ← IDLE.
  - `alarm` drops and the tick counter is reset.
- `load`:
  - Accepted only when `model` == 2'b11 and state is IDLE, PAUSE or EXPIRED.
  - Result: count ← `preset`, state ← IDLE, `alarm` ← 0.
  - Ignored in RUN.
- Preset validity: a preset is invalid if any digit is > 9 or s1 > 5. An invalid load leaves the count and state unchanged and pulses `load_err`.
- State transitions:
  - IDLE → RUN: `run` = 1, `model` == 2'b11, and count ≠ 0. If count = 0, stay in IDLE.
  - RUN → PAUSE: `run` = 0 or `model` ≠ 2'b11. The count is held.
  - PAUSE → RUN: `run` = 1 and `model` == 2'b11. Ticking resumes with the tick counter zeroed.
  - RUN → EXPIRED: on the tick that decrements the count from 24'h000001 to 0. `done` pulses.
  - EXPIRED → IDLE: after `ALARM_TICKS` ticks. `run` is ignored in EXPIRED. On return to IDLE the count is 0, so the timer does not restart.
- BCD decrement, one step per tick in RUN, with borrow chaining:
  - ms0 0→9, borrowing from ms1.
  - ms1 0→9, borrowing from s0.
  - s0 0→9, borrowing from s1.
  - s1 0→5, borrowing from m0.
  - m0 0→9, borrowing from m1.
  - m1 decrements.
  - The count never underflows, because expiry stops decrementing at 0.
- Maximum count is 99:59.99.

## Timing

- Tick generator:
  - Counter runs 0..`TICK_DIV`−1 in RUN and EXPIRED only.
  - The tick enable is high for one cycle when the counter equals `TICK_DIV`−1, then the counter wraps to 0.
  - The counter is zeroed on every entry to RUN and to EXPIRED, and on `clear`.
- First decrement: exactly `TICK_DIV` cycles after the RUN entry edge.
- Output latency:
  - `timer_num` shows the new value on the cycle after the tick-enable edge.
  - `done`, `running` and `load_err` are registered and valid 1 cycle after the causing edge.
  - `done` is coincident with `timer_num` becoming 0.
- `alarm` rises together with `done` and falls on the cycle state returns to IDLE, giving `ALARM_TICKS`×`TICK_DIV` cycles high.
- `load` and `clear` take effect 1 cycle after the sampling edge.
- Simultaneous events:
  - `load` together with a tick in RUN: `load` is ignored and the tick wins.
  - `clear` together with a tick: `clear` wins and `done` is not pulsed.
- `rst` mid-count or mid-alarm: all outputs return to reset values on the next edge.

## Structure

- Shared package:
  - Mode encodings, including MODE_TIMER = 2'b11 and the stopwatch mode 2'b10.
  - The 4-value state enum.
  - Digit-limit constants 9 and 5.
- Sub-module `tick_gen`:
  - Parameter `TICK_DIV`.
  - Inputs `clk`, `rst`, `en`, `restart`.
  - Output `tick`.
  - Replaces the divided-clock-plus-edge-detect scheme with a clean one-cycle enable.
- The BCD decrement is a combinational function in the package; all state is in the top module.

## Test plan

All scenarios use `TICK_DIV` = 4 and `ALARM_TICKS` = 3.

1. Load 24'h000012, hold `run` = 1.
   - `timer_num` goes 12 → 11 → … → 00, one step every 4 cycles.
   - `done` pulses once, the same cycle `timer_num` becomes 0.
   - `alarm` is high for 12 cycles, then the state is IDLE.
2. Load 24'h010000 (01:00.00), run for 1 tick.
   - `timer_num` = 24'h005999.
3. Run from 24'h000050, drop `run` after 2 ticks (value 48) for 20 cycles, then raise `run`.
   - `timer_num` holds 24'h000048 while paused.
   - The next decrement comes exactly 4 cycles after resume.
4. Load 24'h00A000, then load 24'h006000.
   - Each load pulses `load_err` once and `timer_num` keeps its prior value.
   - `load` while `running` = 1 is ignored.
5. Assert `clear` on the same cycle as a tick at value 24'h000001.
   - `timer_num` = 0, state IDLE, no `done` pulse, `alarm` = 0.
6. Run, then set `model` = 2'b10 for 10 cycles, then restore 2'b11.
   - The count is frozen while `model` = 2'b10 and `running` = 0.
   - Counting resumes after 2'b11 is restored.
   - `rst` asserted mid-alarm clears all outputs on the next edge.
